uart_rx_byte: RTL and testbench

- Bit-level UART receiver for the adaptive UART path.
- Synchronises the raw serial pin, detects and qualifies start bits, and samples each bit at mid-bit.
- Emits each good byte as a single-cycle valid pulse, which is the byte stream the receive-buffering/gap-burst stage consumes.
- Reports framing and parity errors as one-cycle pulses and drops the affected bytes.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_bit_sync.sv | 34 +++
 rtl/uart_rx_byte.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - uart_state_e : receiver FSM state encoding
//   - ParityEven / ParityOdd : parity-mode constants
//   - calc_div()   : clocks-per-bit from clock frequency and baud rate
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StBreak  = 3'd5
    } uart_state_e;

    localparam bit ParityEven = 1'b0;
    localparam bit ParityOdd  = 1'b1;

    // Integer floor of clk_freq / baud; callers must keep the result >= 4.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// uart_bit_sync: two-flop synchroniser for the raw serial pin plus a history
// flop for falling-edge detection. All flops reset to 1 (idle line) so that
// reset release never looks like a start bit.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_din    : raw asynchronous serial input
//   o_sync   : synchronised line level (s2)
//   o_fall   : high for one cycle when the synchronised line goes 1 -> 0
module uart_bit_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_sync,
    output logic o_fall
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= i_din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign o_sync = s2_q;
    assign o_fall = s3_q & ~s2_q;

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: bit-level UART receiver. Qualifies the start bit at mid-bit,
// samples each following bit at mid-bit, and emits each good frame as a
// one-cycle valid pulse. Framing and parity errors pulse their own outputs
// and the byte is dropped.
//   i_clk           : system clock, rising edge
//   i_rst_n         : asynchronous active-low reset
//   i_uart_rx       : raw serial line, idles high
//   o_rx_data       : received byte, meaningful only with o_rx_valid
//   o_rx_valid      : one-cycle pulse per good frame
//   o_rx_frame_err  : one-cycle pulse when the stop bit samples 0
//   o_rx_parity_err : one-cycle pulse on parity mismatch
//   o_rx_busy       : high whenever the FSM is not idle
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned P_CLK_FREQ   = 50_000_000,
    parameter int unsigned P_BAUD       = 115200,
    parameter int unsigned P_DIV        = calc_div(P_CLK_FREQ, P_BAUD),
    parameter int unsigned P_DATA_W     = 8,
    parameter bit          P_PARITY_EN  = 1'b0,
    parameter bit          P_PARITY_ODD = ParityEven
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_uart_rx,
    output logic [P_DATA_W-1:0] o_rx_data,
    output logic                o_rx_valid,
    output logic                o_rx_frame_err,
    output logic                o_rx_parity_err,
    output logic                o_rx_busy
);

    localparam int unsigned BaudW = $clog2(P_DIV);
    localparam int unsigned BitW  = $clog2(P_DATA_W + 1);

    localparam logic [BaudW-1:0] BaudHalf = BaudW'(P_DIV / 2 - 1);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(P_DIV - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(P_DATA_W - 1);
    localparam bit               OddPar   = (P_PARITY_ODD == ParityOdd);

    logic rx_sync, rx_fall;

    uart_bit_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_din   (i_uart_rx),
        .o_sync  (rx_sync),
        .o_fall  (rx_fall)
    );

    uart_state_e         state_q, state_d;
    logic [BaudW-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [P_DATA_W-1:0] shift_q, shift_d;
    logic [P_DATA_W-1:0] data_q, data_d;
    logic                par_err_q, par_err_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                perr_q, perr_d;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (rx_fall) begin
                    state_d   = StStart;
                    par_err_d = 1'b0;
                end
            end
            StStart: begin
                if (baud_cnt_q == BaudHalf) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d    = rx_sync ? StIdle : StData;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_sync, shift_q[P_DATA_W-1:1]};
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
                        state_d   = P_PARITY_EN ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    // Mismatch when received bit differs from expected parity.
                    par_err_d  = rx_sync ^ (^shift_q) ^ OddPar;
                    state_d    = StStop;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_cnt_q == BaudLast) begin
                    baud_cnt_d = '0;
                    if (rx_sync) begin
                        // Back to idle at mid stop bit: half a bit of resync margin.
                        state_d = StIdle;
                        if (par_err_q) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // Hold off start detection until the line has returned high.
                baud_cnt_d = '0;
                if (rx_sync) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            par_err_q  <= par_err_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end

    assign o_rx_data       = data_q;
    assign o_rx_valid      = valid_q;
    assign o_rx_frame_err  = ferr_q;
    assign o_rx_parity_err = perr_q;
    assign o_rx_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: one 8N1 instance (line rx_a) and one
// 8E1 instance (line rx_b), both with 16 clocks per bit.
module tb_uart_rx_byte;

    localparam int Div = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, ferr_a, perr_a, busy_a;
    logic       valid_b, ferr_b, perr_b, busy_b;

    always #5 clk = ~clk;

    uart_rx_byte #(
        .P_DIV        (Div),
        .P_DATA_W     (8),
        .P_PARITY_EN  (1'b0),
        .P_PARITY_ODD (1'b0)
    ) u_dut_a (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_uart_rx       (rx_a),
        .o_rx_data       (data_a),
        .o_rx_valid      (valid_a),
        .o_rx_frame_err  (ferr_a),
        .o_rx_parity_err (perr_a),
        .o_rx_busy       (busy_a)
    );

    uart_rx_byte #(
        .P_DIV        (Div),
        .P_DATA_W     (8),
        .P_PARITY_EN  (1'b1),
        .P_PARITY_ODD (1'b0)
    ) u_dut_b (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_uart_rx       (rx_b),
        .o_rx_data       (data_b),
        .o_rx_valid      (valid_b),
        .o_rx_frame_err  (ferr_b),
        .o_rx_parity_err (perr_b),
        .o_rx_busy       (busy_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Pulse logs: cycle number (posedge count) at which each pulse was seen.
    int         va_cyc[$];
    logic [7:0] va_dat[$];
    int         fa_cyc[$];
    int         pa_cyc[$];
    int         vb_cyc[$];
    logic [7:0] vb_dat[$];
    int         fb_cyc[$];
    int         pb_cyc[$];
    int         busy_fall_a = -1;
    logic       busy_a_prev = 1'b0;
    int         n_overlap   = 0;

    always @(negedge clk) begin
        if (valid_a) begin
            va_cyc.push_back(cyc);
            va_dat.push_back(data_a);
        end
        if (ferr_a) fa_cyc.push_back(cyc);
        if (perr_a) pa_cyc.push_back(cyc);
        if (valid_b) begin
            vb_cyc.push_back(cyc);
            vb_dat.push_back(data_b);
        end
        if (ferr_b) fb_cyc.push_back(cyc);
        if (perr_b) pb_cyc.push_back(cyc);
        if ($countones({valid_a, ferr_a, perr_a}) > 1 ||
            $countones({valid_b, ferr_b, perr_b}) > 1) n_overlap++;
        if (busy_a_prev && !busy_a) busy_fall_a = cyc;
        busy_a_prev = busy_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) rx_b = v;
        else     rx_a = v;
        tick(n);
    endtask

    // n0 is the first clock edge that samples the start bit low.
    task automatic send(input bit sel, input logic [7:0] d, input bit par,
                        input logic pbit, input logic stop, output int n0);
        n0 = cyc + 1;
        drive(sel, 1'b0, Div);
        for (int i = 0; i < 8; i++) drive(sel, d[i], Div);
        if (par) drive(sel, pbit, Div);
        drive(sel, stop, Div);
    endtask

    initial begin
        int         n0, n1, n2, base, nf, np;
        logic [7:0] d99;

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        tick(3);
        chk("rst_data", 32'(data_a), 32'h0);
        chk("rst_flags", 32'({valid_a, ferr_a, perr_a, busy_a}), 32'h0);
        rst_n = 1'b1;
        tick(4);
        chk("rst_release_idle", 32'(busy_a), 32'h0);

        // 1: single 8N1 frame 0xA5.
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, n0);
        tick(20);
        chk("t1_nvalid", va_cyc.size(), 1);
        chk("t1_latency", va_cyc[0] - n0, 154);
        chk("t1_data", 32'(va_dat[0]), 32'hA5);
        chk("t1_no_err", fa_cyc.size() + pa_cyc.size(), 0);
        chk("t1_busy_fall", busy_fall_a - n0, 154);

        // 2: six-clock glitch is rejected at the start-bit sample.
        n0 = cyc + 1;
        drive(1'b0, 1'b0, 6);
        chk("t2_busy_in_start", 32'(busy_a), 32'h1);
        drive(1'b0, 1'b1, 6);
        chk("t2_busy_after_glitch", 32'(busy_a), 32'h0);
        tick(20);
        chk("t2_no_pulse", va_cyc.size() + fa_cyc.size() + pa_cyc.size(), 1);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, n0);
        tick(20);
        chk("t2_nvalid", va_cyc.size(), 2);
        chk("t2_data", 32'(va_dat[1]), 32'h3C);
        chk("t2_latency", va_cyc[1] - n0, 154);

        // 3: framing error followed by a held-low line.
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, n0);
        drive(1'b0, 1'b0, 64);
        chk("t3_busy_break", 32'(busy_a), 32'h1);
        chk("t3_nferr", fa_cyc.size(), 1);
        chk("t3_ferr_latency", fa_cyc[0] - n0, 154);
        chk("t3_no_valid", va_cyc.size(), 2);
        drive(1'b0, 1'b1, 5);
        chk("t3_busy_released", 32'(busy_a), 32'h0);
        tick(20);
        chk("t3_single_ferr", fa_cyc.size() + pa_cyc.size(), 1);
        send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, n0);
        tick(20);
        chk("t3_nvalid", va_cyc.size(), 3);
        chk("t3_data", 32'(va_dat[2]), 32'h81);

        // 4: even parity on the parity-enabled instance.
        send(1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, n0);
        tick(20);
        chk("t4_good_nvalid", vb_cyc.size(), 1);
        chk("t4_good_data", 32'(vb_dat[0]), 32'h0F);
        chk("t4_good_latency", vb_cyc[0] - n0, 170);
        chk("t4_good_no_perr", pb_cyc.size(), 0);
        send(1'b1, 8'h0F, 1'b1, 1'b1, 1'b1, n0);
        tick(20);
        chk("t4_bad_nperr", pb_cyc.size(), 1);
        chk("t4_bad_perr_latency", pb_cyc[0] - n0, 170);
        chk("t4_bad_no_valid", vb_cyc.size(), 1);
        chk("t4_no_ferr", fb_cyc.size(), 0);

        // 5: back-to-back frames with no idle gap.
        base = va_cyc.size();
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, n0);
        send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, n1);
        send(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, n2);
        tick(20);
        chk("t5_nvalid", va_cyc.size(), base + 3);
        chk("t5_data0", 32'(va_dat[base]), 32'h00);
        chk("t5_data1", 32'(va_dat[base + 1]), 32'hFF);
        chk("t5_data2", 32'(va_dat[base + 2]), 32'h12);
        chk("t5_latency0", va_cyc[base] - n0, 154);
        chk("t5_gap01", va_cyc[base + 1] - va_cyc[base], 160);
        chk("t5_gap12", va_cyc[base + 2] - va_cyc[base + 1], 160);

        // 6: reset during data bit 4 of 0x99.
        d99 = 8'h99;
        drive(1'b0, 1'b0, Div);
        for (int i = 0; i < 4; i++) drive(1'b0, d99[i], Div);
        drive(1'b0, d99[4], 8);
        chk("t6_busy_before_rst", 32'(busy_a), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", 32'(data_a), 32'h0);
        chk("t6_rst_flags", 32'({valid_a, ferr_a, perr_a, busy_a}), 32'h0);
        base = va_cyc.size();
        nf   = fa_cyc.size();
        np   = pa_cyc.size();
        rx_a = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(40);
        chk("t6_no_spurious", va_cyc.size() + fa_cyc.size() + pa_cyc.size(), base + nf + np);
        chk("t6_idle_after_rst", 32'(busy_a), 32'h0);
        send(1'b0, 8'h99, 1'b0, 1'b0, 1'b1, n0);
        tick(20);
        chk("t6_nvalid", va_cyc.size(), base + 1);
        chk("t6_data", 32'(va_dat[base]), 32'h99);
        chk("t6_latency", va_cyc[base] - n0, 154);

        chk("pulse_exclusive", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
